// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped I/O hub sitting on the CPU MMIO bus.
//   CLK, RESET             : single clock, asynchronous active-high reset
//   IOBUS_ADDR/OUT/WR      : CPU address, write data and write strobe
//   IOBUS_IN               : read data, combinational from IOBUS_ADDR
//   OUT_REGS / OUT_WE      : N_OUT 32-bit output registers and update pulses
//   IN_PORTS               : N_IN 32-bit input ports, read unregistered
//   IRQ_SRC / INTR         : rising-edge interrupt sources, registered request
//   TX_DATA/VALID/READY    : byte FIFO drain handshake
module mmio_io_hub #(
  parameter int unsigned N_OUT      = 4,
  parameter int unsigned N_IN       = 4,
  parameter int unsigned N_IRQ      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] OUT_BASE   = 32'h11080000,
  parameter logic [31:0] IN_BASE    = 32'h11000000,
  parameter logic [31:0] CTL_BASE   = 32'h11400000,
  parameter logic [31:0] SPACING    = 32'h00040000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         IOBUS_ADDR,
  input  logic [31:0]         IOBUS_OUT,
  input  logic                IOBUS_WR,
  output logic [31:0]         IOBUS_IN,
  output logic [N_OUT*32-1:0] OUT_REGS,
  output logic [N_OUT-1:0]    OUT_WE,
  input  logic [N_IN*32-1:0]  IN_PORTS,
  input  logic [N_IRQ-1:0]    IRQ_SRC,
  output logic                INTR,
  output logic [7:0]          TX_DATA,
  output logic                TX_VALID,
  input  logic                TX_READY
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [31:0] PEND_ADDR = CTL_BASE;
  localparam logic [31:0] EN_ADDR   = CTL_BASE + SPACING;
  localparam logic [31:0] DATA_ADDR = CTL_BASE + 2 * SPACING;
  localparam logic [31:0] STAT_ADDR = CTL_BASE + 3 * SPACING;

  // Registered state
  logic [N_OUT-1:0][31:0] out_q, out_d;
  logic [N_OUT-1:0]       out_we_q, out_we_d;
  logic [N_IRQ-1:0]       hist_q, pend_q, pend_d, en_q, en_d;
  logic                   intr_q;
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             mem_q [FIFO_DEPTH];

  // Address decode
  logic [N_OUT-1:0] out_hit;
  logic [N_IN-1:0]  in_hit;
  logic             wr_pend, wr_en, wr_data, wr_stat;

  always_comb begin
    out_hit = '0;
    in_hit  = '0;
    for (int unsigned i = 0; i < N_OUT; i++)
      out_hit[i] = (IOBUS_ADDR == OUT_BASE + SPACING * i);
    for (int unsigned i = 0; i < N_IN; i++)
      in_hit[i] = (IOBUS_ADDR == IN_BASE + SPACING * i);
  end

  assign wr_pend = IOBUS_WR && (IOBUS_ADDR == PEND_ADDR);
  assign wr_en   = IOBUS_WR && (IOBUS_ADDR == EN_ADDR);
  assign wr_data = IOBUS_WR && (IOBUS_ADDR == DATA_ADDR);
  assign wr_stat = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR);

  // FIFO status and handshake
  logic fifo_empty, fifo_full, pop, push_ok, ovf_set;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && TX_READY;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok    = wr_data && (!fifo_full || pop);
  assign ovf_set    = wr_data && fifo_full && !pop;

  assign TX_VALID = !fifo_empty;
  assign TX_DATA  = mem_q[rptr_q];

  // Read mux. With the default map OUT reg i and IN port i+2 share an address;
  // the IN port is listed last so it wins the read, the OUT reg keeps the write.
  always_comb begin
    IOBUS_IN = '0;
    for (int unsigned i = 0; i < N_OUT; i++)
      if (out_hit[i]) IOBUS_IN = out_q[i];
    for (int unsigned i = 0; i < N_IN; i++)
      if (in_hit[i]) IOBUS_IN = IN_PORTS[32*i +: 32];
    if (IOBUS_ADDR == PEND_ADDR) IOBUS_IN = 32'(pend_q);
    if (IOBUS_ADDR == EN_ADDR)   IOBUS_IN = 32'(en_q);
    if (IOBUS_ADDR == STAT_ADDR)
      IOBUS_IN = {16'h0000, 8'(count_q), 5'b00000, ovf_q, fifo_full, fifo_empty};
  end

  // Next-state logic
  always_comb begin
    out_we_d = out_hit & {N_OUT{IOBUS_WR}};
    out_d    = out_q;
    for (int unsigned i = 0; i < N_OUT; i++)
      if (out_we_d[i]) out_d[i] = IOBUS_OUT;

    // W1C clear first, new edges OR'd in last so a simultaneous edge survives
    pend_d = (pend_q & ~(wr_pend ? IOBUS_OUT[N_IRQ-1:0] : '0)) | (IRQ_SRC & ~hist_q);
    en_d   = wr_en ? IOBUS_OUT[N_IRQ-1:0] : en_q;

    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q && !wr_stat) || ovf_set;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q    <= '0;
      out_we_q <= '0;
      hist_q   <= '1;  // sources already high at reset release are not edges
      pend_q   <= '0;
      en_q     <= '0;
      intr_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_we_q <= out_we_d;
      hist_q   <= IRQ_SRC;
      pend_q   <= pend_d;
      en_q     <= en_d;
      intr_q   <= |(pend_q & en_q);
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: emptiness is carried by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wptr_q] <= IOBUS_OUT[7:0];
  end

  assign OUT_REGS = out_q;
  assign OUT_WE   = out_we_q;
  assign INTR     = intr_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Scoreboard bench for mmio_io_hub: the stimulus side updates a behavioural
// model and queues expected TX bytes and OUT_WE pulses; a negedge monitor
// consumes them whenever the DUT presents a handshake or pulse.
module tb_mmio_io_hub;

  localparam logic [31:0] OUT_BASE = 32'h11080000;
  localparam logic [31:0] IN_BASE  = 32'h11000000;
  localparam logic [31:0] CTL_BASE = 32'h11400000;
  localparam logic [31:0] SP       = 32'h00040000;
  localparam logic [31:0] A_PEND   = CTL_BASE;
  localparam logic [31:0] A_EN     = CTL_BASE + SP;
  localparam logic [31:0] A_DATA   = CTL_BASE + 2 * SP;
  localparam logic [31:0] A_STAT   = CTL_BASE + 3 * SP;
  localparam int          DEPTH    = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  addr, wdata;
  logic         wr;
  logic [31:0]  IOBUS_IN;
  logic [127:0] OUT_REGS;
  logic [3:0]   OUT_WE;
  logic [127:0] in_ports;
  logic [3:0]   irq_src;
  logic         INTR;
  logic [7:0]   TX_DATA;
  logic         TX_VALID;
  logic         tx_ready;

  mmio_io_hub #(
    .N_OUT(4), .N_IN(4), .N_IRQ(4), .FIFO_DEPTH(DEPTH),
    .OUT_BASE(OUT_BASE), .IN_BASE(IN_BASE), .CTL_BASE(CTL_BASE), .SPACING(SP)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr), .IOBUS_IN(IOBUS_IN),
    .OUT_REGS(OUT_REGS), .OUT_WE(OUT_WE), .IN_PORTS(in_ports),
    .IRQ_SRC(irq_src), .INTR(INTR),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(tx_ready)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [31:0] out_m [4];
  logic [3:0]  pend_m, en_m, src_prev_m;
  logic        intr_m, ovf_m;
  logic [7:0]  fifo_m [$];

  // Scoreboard queues
  logic [7:0]  exp_tx [$];
  int          exp_we_idx [$];
  logic [31:0] exp_we_val [$];

  logic [31:0] rd_list [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a == IN_BASE + SP * i) return in_ports[32*i +: 32];
    for (int i = 0; i < 4; i++)
      if (a == OUT_BASE + SP * i) return out_m[i];
    if (a == A_PEND) return {28'h0, pend_m};
    if (a == A_EN)   return {28'h0, en_m};
    if (a == A_STAT)
      return {16'h0, 8'(fifo_m.size()), 5'b0, ovf_m,
              fifo_m.size() == DEPTH, fifo_m.size() == 0};
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) out_m[i] = '0;
    pend_m = '0; en_m = '0; src_prev_m = '1; intr_m = 1'b0; ovf_m = 1'b0;
    fifo_m.delete(); exp_tx.delete(); exp_we_idx.delete(); exp_we_val.delete();
  endtask

  // One clock edge: apply the rules for the inputs presented before the edge.
  task automatic step();
    logic [3:0] clr;
    logic       push, pop, was_full, intr_next;
    @(posedge CLK);
    intr_next = |(pend_m & en_m);
    clr  = '0;
    push = 1'b0;
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (addr == OUT_BASE + SP * i) begin
          out_m[i] = wdata;
          exp_we_idx.push_back(i);
          exp_we_val.push_back(wdata);
        end
      if (addr == A_PEND) clr = wdata[3:0];
      if (addr == A_EN)   en_m = wdata[3:0];
      if (addr == A_DATA) push = 1'b1;
      if (addr == A_STAT) ovf_m = 1'b0;
    end
    pend_m = (pend_m & ~clr) | (irq_src & ~src_prev_m);
    src_prev_m = irq_src;
    was_full = (fifo_m.size() == DEPTH);
    pop = (fifo_m.size() > 0) && tx_ready;
    if (pop) void'(fifo_m.pop_front());
    if (push) begin
      if (!was_full || pop) begin
        fifo_m.push_back(wdata[7:0]);
        exp_tx.push_back(wdata[7:0]);
      end else ovf_m = 1'b1;
    end
    intr_m = intr_next;
    #1;
    wr = 1'b0;
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    step();
  endtask

  task automatic rd(input string name, input logic [31:0] a);
    addr = a; wr = 1'b0;
    #1;
    chk(name, IOBUS_IN, model_read(a));
  endtask

  task automatic do_reset();
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    chk("rst_tx_valid", {31'h0, TX_VALID}, 32'h0);
    chk("rst_out_regs_lo", OUT_REGS[63:0] == 64'h0, 32'h1);
    chk("rst_out_regs_hi", OUT_REGS[127:64] == 64'h0, 32'h1);
    chk("rst_out_we", {28'h0, OUT_WE}, 32'h0);
    chk("rst_intr", {31'h0, INTR}, 32'h0);
    rd("rst_stat", A_STAT);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  // Monitor: consumes expected TX bytes and OUT_WE pulses as the DUT shows them.
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      if (TX_VALID && tx_ready) begin
        if (exp_tx.size() == 0) flag("tx_unexpected");
        else chk("tx_data", {24'h0, TX_DATA}, {24'h0, exp_tx.pop_front()});
      end
      for (int i = 0; i < 4; i++)
        if (OUT_WE[i]) begin
          if (exp_we_idx.size() == 0) flag("out_we_unexpected");
          else begin
            chk("out_we_idx", i, exp_we_idx.pop_front());
            chk("out_we_val", OUT_REGS[32*i +: 32], exp_we_val.pop_front());
          end
        end
    end
  end

  initial begin
    addr = '0; wdata = '0; wr = 1'b0; in_ports = '0; irq_src = '0; tx_ready = 1'b0;
    RESET = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rd_list[i]     = IN_BASE + SP * i;
      rd_list[i + 4] = OUT_BASE + SP * i;
    end
    rd_list[8] = A_PEND; rd_list[9] = A_EN; rd_list[10] = A_STAT;
    rd_list[11] = OUT_BASE + 32'h4;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_we", {28'h0, OUT_WE}, 32'h0);
    chk("reset_intr", {31'h0, INTR}, 32'h0);
    chk("reset_tx_valid", {31'h0, TX_VALID}, 32'h0);
    addr = A_STAT; #1;
    chk("reset_stat", IOBUS_IN, 32'h00000001);
    RESET = 1'b0;

    // Output register write and one-cycle update pulse
    wr_op(32'h110C0000, 32'hDEADBEEF);
    chk("out1_value", OUT_REGS[63:32], 32'hDEADBEEF);
    chk("out1_we", {28'h0, OUT_WE}, 32'h00000002);
    step();
    chk("out1_we_drop", {28'h0, OUT_WE}, 32'h0);

    // Input port read and non-exact address
    in_ports[95:64] = 32'h0000A5A5;
    addr = 32'h11080000; #1;
    chk("in2_read", IOBUS_IN, 32'h0000A5A5);
    rd("in2_model", 32'h11080000);
    rd("nomatch_read", 32'h11000004);
    rd("out1_read", 32'h110C0000);

    // Interrupt edge, INTR latency, W1C racing a new edge
    wr_op(A_EN, 32'h00000004);
    irq_src = 4'b0100;
    step();
    chk("intr_not_yet", {31'h0, INTR}, {31'h0, intr_m});
    step();
    chk("intr_high", {31'h0, INTR}, 32'h1);
    irq_src = 4'b0000;
    step();
    irq_src = 4'b0100;
    wr_op(A_PEND, 32'h00000004);
    rd("pend_kept", A_PEND);
    chk("pend_kept_val", IOBUS_IN, 32'h00000004);
    step();
    chk("intr_kept", {31'h0, INTR}, 32'h1);
    irq_src = 4'b0000;
    wr_op(A_PEND, 32'h00000004);
    step();
    chk("intr_cleared", {31'h0, INTR}, {31'h0, intr_m});
    rd("pend_cleared", A_PEND);

    // Overflow with the drain stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr_op(A_DATA, 32'hA0 + i);
    addr = A_STAT; #1;
    chk("stat_ovf", IOBUS_IN, 32'h00000806);
    wr_op(A_STAT, 32'h0);
    addr = A_STAT; #1;
    chk("stat_ovf_clr", IOBUS_IN, 32'h00000802);

    // Push and pop together while full, then drain across the wrap
    tx_ready = 1'b1;
    wr_op(A_DATA, 32'h000000C3);
    addr = A_STAT; #1;
    chk("stat_full_pushpop", IOBUS_IN, 32'h00000802);
    for (int i = 0; i < 20 && fifo_m.size() > 0; i++) step();
    chk("drain1_left", fifo_m.size(), 0);
    rd("stat_drained", A_STAT);

    // Reset mid-drain with count 5 and INTR high; IRQ_SRC held through reset
    irq_src = 4'b0100;
    step();
    step();
    chk("intr_before_rst", {31'h0, INTR}, 32'h1);
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr_op(A_DATA, 32'h50 + i);
    tx_ready = 1'b1;
    step();
    rd("stat_count5", A_STAT);
    do_reset();
    repeat (3) step();
    rd("pend_after_rst", A_PEND);
    chk("intr_after_rst", {31'h0, INTR}, 32'h0);

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      int unsigned op;
      irq_src  = 4'($urandom);
      tx_ready = ((c / 40) % 2 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) in_ports = {$urandom, $urandom, $urandom, $urandom};
      op = $urandom_range(0, 9);
      case (op)
        0: wr_op(OUT_BASE + SP * $urandom_range(0, 3), $urandom);
        1: wr_op(A_EN, $urandom);
        2: wr_op(A_PEND, $urandom);
        3, 4, 5: wr_op(A_DATA, $urandom);
        6: wr_op(A_STAT, $urandom);
        7: wr_op(OUT_BASE + 32'h4 * $urandom_range(1, 3), $urandom);
        default: step();
      endcase
      chk("rnd_intr", {31'h0, INTR}, {31'h0, intr_m});
      chk("rnd_tx_valid", {31'h0, TX_VALID}, {31'h0, fifo_m.size() > 0});
      rd("rnd_read", rd_list[$urandom_range(0, 11)]);
    end

    // Final drain; bounded
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && fifo_m.size() > 0; i++) step();
    step();
    @(negedge CLK);
    #1;
    chk("final_fifo_model", fifo_m.size(), 0);
    chk("final_tx_pending", exp_tx.size(), 0);
    chk("final_we_pending", exp_we_idx.size(), 0);
    rd("final_stat", A_STAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
